fc8_vram_arbiter: RTL

Single-port VRAM access controller for the FC8 system. It shares the VRAM port between three requesters: graphics pixel/tile fetch, CPU accesses through the MMU VRAM window, and a built-in hardware fill engine that the SFR block uses for screen clears. It applies fixed priority (graphics > CPU > fill) with a bounded-wait override so the CPU cannot be starved by back-to-back graphics fetches.

---
 rtl/fc8_vram_arbiter_if.sv | 67 ++++++
 rtl/fc8_vram_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fc8_vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fc8_vram_arbiter_if
// Purpose  : Bundles the request/response signals of the FC8 VRAM arbiter.
//            Three requester groups (graphics, CPU, fill engine) plus the
//            single VRAM port.
//   slave  : view of the arbiter itself (takes requests, drives VRAM)
//   master : view of the surrounding system (requesters + VRAM model)
// Ports    : gfx_*  graphics read port
//            cpu_*  CPU read/write port (held until cpu_ready)
//            fill_* hardware fill engine control/status
//            vram_* single-port VRAM strobe/address/data
// Revision : 1.0  initial release
// ============================================================================
interface fc8_vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              gfx_req;
  logic [ADDR_W-1:0] gfx_addr;
  logic              gfx_gnt;
  logic              gfx_rvalid;
  logic [DATA_W-1:0] gfx_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;

  logic              fill_start;
  logic [ADDR_W-1:0] fill_addr;
  logic [ADDR_W-1:0] fill_len;
  logic [DATA_W-1:0] fill_value;
  logic              fill_busy;
  logic              fill_done;

  logic              vram_en;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_wdata;
  logic [DATA_W-1:0] vram_rdata;

  modport slave (
    input  gfx_req, gfx_addr,
    output gfx_gnt, gfx_rvalid, gfx_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rdata,
    input  fill_start, fill_addr, fill_len, fill_value,
    output fill_busy, fill_done,
    output vram_en, vram_we, vram_addr, vram_wdata,
    input  vram_rdata
  );

  modport master (
    output gfx_req, gfx_addr,
    input  gfx_gnt, gfx_rvalid, gfx_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rdata,
    output fill_start, fill_addr, fill_len, fill_value,
    input  fill_busy, fill_done,
    input  vram_en, vram_we, vram_addr, vram_wdata,
    output vram_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fc8_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fc8_vram_arbiter
// Purpose  : Single-port VRAM access controller. Shares the VRAM port between
//            graphics fetch, CPU window accesses and a built-in fill engine.
//            Fixed priority gfx > CPU > fill, with a bounded-wait override that
//            lets the CPU beat graphics once after CPU_MAX_WAIT lost edges.
// Ports    : master_clk  system clock (rising edge)
//            master_rst  asynchronous active-high reset
//            bus         fc8_vram_arbiter_if.slave (gfx_*, cpu_*, fill_*,
//                        vram_*)
// Revision : 1.0  initial release
// ============================================================================
module fc8_vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int CPU_MAX_WAIT = 8
) (
  input  wire               master_clk,
  input  wire               master_rst,
  fc8_vram_arbiter_if.slave bus
);

  localparam int                C_WAIT_W   = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
  localparam logic [C_WAIT_W-1:0] C_WAIT_MAX = C_WAIT_W'(CPU_MAX_WAIT);
  localparam bit                C_OVR_EN   = (CPU_MAX_WAIT != 0);

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_RD1  = 2'd1,
    C_RD2  = 2'd2
  } cpu_state_t;

  typedef enum logic [0:0] {
    F_IDLE = 1'b0,
    F_RUN  = 1'b1
  } fill_state_t;

  cpu_state_t          r_cpu_state;
  fill_state_t         r_fill_state;
  logic [C_WAIT_W-1:0] r_wait_cnt;
  logic [ADDR_W-1:0]   r_fill_addr;
  logic [ADDR_W-1:0]   r_fill_cnt;
  logic [DATA_W-1:0]   r_fill_value;

  logic                r_vram_en;
  logic                r_vram_we;
  logic [ADDR_W-1:0]   r_vram_addr;
  logic [DATA_W-1:0]   r_vram_wdata;
  logic                r_gfx_gnt;
  logic                r_gfx_p1;      // gfx read in flight, data arrives next edge
  logic                r_gfx_rvalid;
  logic [DATA_W-1:0]   r_gfx_rdata;
  logic                r_cpu_ready;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic                r_fill_busy;
  logic                r_fill_done;

  logic                w_gfx_elig;
  logic                w_cpu_elig;
  logic                w_fill_elig;
  logic                w_cpu_ovr;
  logic                w_gfx_win;
  logic                w_cpu_win;
  logic                w_fill_win;
  logic                w_vram_we;
  logic [ADDR_W-1:0]   w_vram_addr;
  logic [DATA_W-1:0]   w_vram_wdata;

  // The CPU is not eligible in its ready cycle: the requester still holds
  // cpu_req there and must not be granted a duplicate transaction.
  assign w_gfx_elig  = bus.gfx_req;
  assign w_cpu_elig  = bus.cpu_req && (r_cpu_state == C_IDLE) && !r_cpu_ready;
  assign w_fill_elig = (r_fill_state == F_RUN);
  assign w_cpu_ovr   = C_OVR_EN && (r_wait_cnt == C_WAIT_MAX);

  assign w_cpu_win   = w_cpu_elig && (!w_gfx_elig || w_cpu_ovr);
  assign w_gfx_win   = w_gfx_elig && !w_cpu_win;
  assign w_fill_win  = w_fill_elig && !w_gfx_elig && !w_cpu_elig;

  always_comb begin
    w_vram_we    = 1'b0;
    w_vram_addr  = '0;
    w_vram_wdata = '0;
    if (w_gfx_win) begin
      w_vram_addr  = bus.gfx_addr;
    end else if (w_cpu_win) begin
      w_vram_we    = bus.cpu_we;
      w_vram_addr  = bus.cpu_addr;
      w_vram_wdata = bus.cpu_we ? bus.cpu_wdata : '0;
    end else if (w_fill_win) begin
      w_vram_we    = 1'b1;
      w_vram_addr  = r_fill_addr;
      w_vram_wdata = r_fill_value;
    end
  end

  always_ff @(posedge master_clk or posedge master_rst) begin
    if (master_rst) begin
      r_cpu_state  <= C_IDLE;
      r_fill_state <= F_IDLE;
      r_wait_cnt   <= '0;
      r_fill_addr  <= '0;
      r_fill_cnt   <= '0;
      r_fill_value <= '0;
      r_vram_en    <= 1'b0;
      r_vram_we    <= 1'b0;
      r_vram_addr  <= '0;
      r_vram_wdata <= '0;
      r_gfx_gnt    <= 1'b0;
      r_gfx_p1     <= 1'b0;
      r_gfx_rvalid <= 1'b0;
      r_gfx_rdata  <= '0;
      r_cpu_ready  <= 1'b0;
      r_cpu_rdata  <= '0;
      r_fill_busy  <= 1'b0;
      r_fill_done  <= 1'b0;
    end else begin
      // VRAM command register
      r_vram_en    <= w_gfx_win || w_cpu_win || w_fill_win;
      r_vram_we    <= w_vram_we;
      r_vram_addr  <= w_vram_addr;
      r_vram_wdata <= w_vram_wdata;

      // Graphics read pipeline: grant -> in flight -> data valid
      r_gfx_gnt    <= w_gfx_win;
      r_gfx_p1     <= r_gfx_gnt;
      r_gfx_rvalid <= r_gfx_p1;
      if (r_gfx_p1) begin
        r_gfx_rdata <= bus.vram_rdata;
      end

      r_cpu_ready  <= 1'b0;
      r_fill_done  <= 1'b0;

      // Bounded-wait counter for the CPU
      if (!bus.cpu_req || w_cpu_win) begin
        r_wait_cnt <= '0;
      end else if (w_cpu_elig && (r_wait_cnt != C_WAIT_MAX)) begin
        r_wait_cnt <= r_wait_cnt + C_WAIT_W'(1);
      end

      // CPU transaction tracking
      case (r_cpu_state)
        C_IDLE: begin
          if (w_cpu_win) begin
            if (bus.cpu_we) begin
              r_cpu_ready <= 1'b1;
            end else begin
              r_cpu_state <= C_RD1;
            end
          end
        end
        C_RD1: begin
          r_cpu_state <= C_RD2;
        end
        C_RD2: begin
          r_cpu_rdata <= bus.vram_rdata;
          r_cpu_ready <= 1'b1;
          r_cpu_state <= C_IDLE;
        end
        default: begin
          r_cpu_state <= C_IDLE;
        end
      endcase

      // Fill engine
      case (r_fill_state)
        F_IDLE: begin
          if (bus.fill_start) begin
            if (bus.fill_len == '0) begin
              r_fill_done <= 1'b1;
            end else begin
              r_fill_addr  <= bus.fill_addr;
              r_fill_cnt   <= bus.fill_len;
              r_fill_value <= bus.fill_value;
              r_fill_busy  <= 1'b1;
              r_fill_state <= F_RUN;
            end
          end
        end
        F_RUN: begin
          if (w_fill_win) begin
            r_fill_addr <= r_fill_addr + ADDR_W'(1);
            r_fill_cnt  <= r_fill_cnt - ADDR_W'(1);
            if (r_fill_cnt == ADDR_W'(1)) begin
              r_fill_busy  <= 1'b0;
              r_fill_done  <= 1'b1;
              r_fill_state <= F_IDLE;
            end
          end
        end
        default: begin
          r_fill_state <= F_IDLE;
        end
      endcase
    end
  end

  assign bus.vram_en    = r_vram_en;
  assign bus.vram_we    = r_vram_we;
  assign bus.vram_addr  = r_vram_addr;
  assign bus.vram_wdata = r_vram_wdata;
  assign bus.gfx_gnt    = r_gfx_gnt;
  assign bus.gfx_rvalid = r_gfx_rvalid;
  assign bus.gfx_rdata  = r_gfx_rdata;
  assign bus.cpu_ready  = r_cpu_ready;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.fill_busy  = r_fill_busy;
  assign bus.fill_done  = r_fill_done;

endmodule
`default_nettype wire
